// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: boot sequencer and RAM-port owner for the TinyMIPS + blram pair.
// Holds the core in reset, streams a program image into blram over a valid/ready
// port, waits a short reset-hold window, then releases the core and hands it the
// RAM port. blram dout goes straight to the core and is not routed through here.
//
// Optional feature: define LOAD_CSUM_EN to add a 16-bit running checksum output
// (csum) of the words written during the most recent load.
//
// Image port handshake: a word is transferred ("beat") in every cycle where
// s_valid and s_ready are both high. s_ready is high exactly while in LOAD and
// does not depend on s_valid; s_valid may drop at any time (gaps are allowed)
// and s_data is only looked at on a beat.
module boot_load_ctrl #(
    parameter int SIZE     = 8,
    parameter int RST_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] base_addr,
    input  logic [SIZE:0]   word_count,
    input  logic            s_valid,
    input  logic [15:0]     s_data,
    output logic            s_ready,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [15:0]     cpu_data,
    output logic            cpu_rst,
    output logic            ram_we,
    output logic [SIZE-1:0] ram_addr,
    output logic [15:0]     ram_din,
    output logic            busy,
    output logic            done,
    output logic            err,
`ifdef LOAD_CSUM_EN
    output logic [15:0]     csum,
`endif
    output logic [1:0]      dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } bootState_t;

    bootState_t      state, stateNext;
    logic [SIZE-1:0] ptr, ptrNext;
    logic [SIZE:0]   remaining, remNext;
    logic [3:0]      holdCnt, holdNext;
    logic            errNext;
    logic            beat;

    // Next-state logic plus the combinational RAM port mux.
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        remNext   = remaining;
        holdNext  = '0;
        errNext   = 1'b0;
        beat      = 1'b0;
        s_ready   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        stateNext = LOAD;
                        ptrNext   = base_addr;
                        remNext   = word_count;
                    end else begin
                        // Zero-length image: just reboot whatever is in RAM.
                        stateNext = HOLD;
                    end
                end
            end
            LOAD: begin
                s_ready  = 1'b1;
                beat     = s_valid;
                ram_we   = s_valid;
                ram_addr = ptr;
                ram_din  = s_data;
                errNext  = start;
                if (s_valid) begin
                    // ptr is SIZE bits wide, so DEPTH-1 wraps to 0 for free.
                    ptrNext = ptr + 1'b1;
                    remNext = remaining - 1'b1;
                    if (remaining == (SIZE+1)'(1)) begin
                        stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                errNext = start;
                // Stay RST_HOLD+1 cycles so RUN starts RST_HOLD+1 edges after
                // the last beat edge.
                if (holdCnt == 4'(RST_HOLD)) begin
                    stateNext = RUN;
                end else begin
                    holdNext = holdCnt + 1'b1;
                end
            end
            RUN: begin
                // The core owns the RAM port, including in the cycle start is seen.
                ram_we   = cpu_wrEn;
                ram_addr = cpu_addr;
                ram_din  = cpu_data;
                if (start) begin
                    if (word_count != '0) begin
                        stateNext = LOAD;
                        ptrNext   = base_addr;
                        remNext   = word_count;
                    end else begin
                        stateNext = HOLD;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, load pointers and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            holdCnt   <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            ptr       <= ptrNext;
            remaining <= remNext;
            holdCnt   <= holdNext;
            cpu_rst   <= (stateNext != RUN);
            done      <= (stateNext == RUN) && (state != RUN);
            err       <= errNext;
        end
    end

`ifdef LOAD_CSUM_EN
    // Running checksum of the current image: cleared on LOAD entry, summed per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if ((stateNext == LOAD) && (state != LOAD)) begin
            csum <= '0;
        end else if (beat) begin
            csum <= csum + s_data;
        end
    end
`endif

    assign busy     = (state == LOAD) || (state == HOLD);
    assign dbgState = state;

endmodule
